// File: rtl/axi_rd_arbiter_2m1s.sv
// rtl/axi_rd_arbiter_2m1s.sv - two-master one-slave AXI-lite arbiter: round-robin reads, m1-only writes
module axi_rd_arbiter_2m1s #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          m0_ar_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     m0_ar_addr_i,
    output logic                          m0_ar_ready_o,
    output logic                          m0_r_valid_o,
    input  logic                          m0_r_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]     m0_r_data_o,
    output logic [1:0]                    m0_r_resp_o,
    input  logic                          m1_ar_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     m1_ar_addr_i,
    output logic                          m1_ar_ready_o,
    output logic                          m1_r_valid_o,
    input  logic                          m1_r_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]     m1_r_data_o,
    output logic [1:0]                    m1_r_resp_o,
    input  logic                          m1_aw_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     m1_aw_addr_i,
    output logic                          m1_aw_ready_o,
    input  logic                          m1_w_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]     m1_w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   m1_w_strb_i,
    output logic                          m1_w_ready_o,
    output logic                          m1_b_valid_o,
    output logic [1:0]                    m1_b_resp_o,
    input  logic                          m1_b_ready_i,
    output logic                          s_ar_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]     s_ar_addr_o,
    input  logic                          s_ar_ready_i,
    input  logic                          s_r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]     s_r_data_i,
    input  logic [1:0]                    s_r_resp_i,
    output logic                          s_r_ready_o,
    output logic                          s_aw_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]     s_aw_addr_o,
    input  logic                          s_aw_ready_i,
    output logic                          s_w_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]     s_w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0]   s_w_strb_o,
    input  logic                          s_w_ready_i,
    input  logic                          s_b_valid_i,
    input  logic [1:0]                    s_b_resp_i,
    output logic                          s_b_ready_o
);
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

    rstate_t rstate, rstate_nxt;
    wstate_t wstate, wstate_nxt;
    logic    grant, grant_nxt, last_grant, last_grant_nxt;
    logic    gnt_ar_valid, gnt_r_ready;

    assign gnt_ar_valid = grant ? m1_ar_valid_i : m0_ar_valid_i;
    assign gnt_r_ready  = grant ? m1_r_ready_i  : m0_r_ready_i;

    // last_grant resets to 1 so the first tie after reset goes to m0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate     <= R_IDLE;
            wstate     <= W_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            rstate     <= rstate_nxt;
            wstate     <= wstate_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        rstate_nxt     = rstate;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        case (rstate)
            R_IDLE: begin
                if (m0_ar_valid_i || m1_ar_valid_i) begin
                    grant_nxt  = (m0_ar_valid_i && m1_ar_valid_i) ? ~last_grant : m1_ar_valid_i;
                    rstate_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                if (!gnt_ar_valid)
                    rstate_nxt = R_IDLE;
                else if (s_ar_ready_i)
                    rstate_nxt = R_DATA;
            end
            R_DATA: begin
                if (s_r_valid_i && gnt_r_ready) begin
                    last_grant_nxt = grant;
                    rstate_nxt     = R_IDLE;
                end
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_IDLE: if (m1_aw_valid_i) wstate_nxt = W_ADDR;
            W_ADDR: if (m1_aw_valid_i && s_aw_ready_i) wstate_nxt = W_DATA;
            W_DATA: if (m1_w_valid_i && s_w_ready_i) wstate_nxt = W_RESP;
            W_RESP: if (s_b_valid_i && m1_b_ready_i) wstate_nxt = W_IDLE;
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        s_ar_valid_o  = 1'b0;
        s_ar_addr_o   = '0;
        m0_ar_ready_o = 1'b0;
        m1_ar_ready_o = 1'b0;
        s_r_ready_o   = 1'b0;
        m0_r_valid_o  = 1'b0;
        m0_r_data_o   = '0;
        m0_r_resp_o   = 2'b00;
        m1_r_valid_o  = 1'b0;
        m1_r_data_o   = '0;
        m1_r_resp_o   = 2'b00;
        case (rstate)
            R_ADDR: begin
                s_ar_valid_o = gnt_ar_valid;
                s_ar_addr_o  = grant ? m1_ar_addr_i : m0_ar_addr_i;
                if (grant) m1_ar_ready_o = s_ar_ready_i;
                else       m0_ar_ready_o = s_ar_ready_i;
            end
            R_DATA: begin
                s_r_ready_o = gnt_r_ready;
                if (grant) begin
                    m1_r_valid_o = s_r_valid_i;
                    m1_r_data_o  = s_r_data_i;
                    m1_r_resp_o  = s_r_resp_i;
                end else begin
                    m0_r_valid_o = s_r_valid_i;
                    m0_r_data_o  = s_r_data_i;
                    m0_r_resp_o  = s_r_resp_i;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        s_aw_valid_o  = 1'b0;
        s_aw_addr_o   = '0;
        m1_aw_ready_o = 1'b0;
        s_w_valid_o   = 1'b0;
        s_w_data_o    = '0;
        s_w_strb_o    = '0;
        m1_w_ready_o  = 1'b0;
        m1_b_valid_o  = 1'b0;
        m1_b_resp_o   = 2'b00;
        s_b_ready_o   = 1'b0;
        case (wstate)
            W_ADDR: begin
                s_aw_valid_o  = m1_aw_valid_i;
                s_aw_addr_o   = m1_aw_addr_i;
                m1_aw_ready_o = s_aw_ready_i;
            end
            W_DATA: begin
                s_w_valid_o  = m1_w_valid_i;
                s_w_data_o   = m1_w_data_i;
                s_w_strb_o   = m1_w_strb_i;
                m1_w_ready_o = s_w_ready_i;
            end
            W_RESP: begin
                m1_b_valid_o = s_b_valid_i;
                m1_b_resp_o  = s_b_resp_i;
                s_b_ready_o  = m1_b_ready_i;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axi_rd_arbiter_2m1s.sv
// tb/tb_axi_rd_arbiter_2m1s.sv - randomized bench for axi_rd_arbiter_2m1s against a phase-level model
module tb_axi_rd_arbiter_2m1s;
    localparam int DW = 64;
    localparam int AW = 64;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_ready;
    logic [AW-1:0] m0_ar_addr;
    logic [DW-1:0] m0_r_data;
    logic [1:0]    m0_r_resp;
    logic          m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_ready;
    logic [AW-1:0] m1_ar_addr;
    logic [DW-1:0] m1_r_data;
    logic [1:0]    m1_r_resp;
    logic          m1_aw_valid, m1_aw_ready, m1_w_valid, m1_w_ready, m1_b_valid, m1_b_ready;
    logic [AW-1:0] m1_aw_addr;
    logic [DW-1:0] m1_w_data;
    logic [SW-1:0] m1_w_strb;
    logic [1:0]    m1_b_resp;
    logic          s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
    logic [AW-1:0] s_ar_addr;
    logic [DW-1:0] s_r_data;
    logic [1:0]    s_r_resp;
    logic          s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
    logic [AW-1:0] s_aw_addr;
    logic [DW-1:0] s_w_data;
    logic [SW-1:0] s_w_strb;
    logic [1:0]    s_b_resp;

    axi_rd_arbiter_2m1s #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .m0_ar_valid_i(m0_ar_valid), .m0_ar_addr_i(m0_ar_addr), .m0_ar_ready_o(m0_ar_ready),
        .m0_r_valid_o(m0_r_valid), .m0_r_ready_i(m0_r_ready), .m0_r_data_o(m0_r_data), .m0_r_resp_o(m0_r_resp),
        .m1_ar_valid_i(m1_ar_valid), .m1_ar_addr_i(m1_ar_addr), .m1_ar_ready_o(m1_ar_ready),
        .m1_r_valid_o(m1_r_valid), .m1_r_ready_i(m1_r_ready), .m1_r_data_o(m1_r_data), .m1_r_resp_o(m1_r_resp),
        .m1_aw_valid_i(m1_aw_valid), .m1_aw_addr_i(m1_aw_addr), .m1_aw_ready_o(m1_aw_ready),
        .m1_w_valid_i(m1_w_valid), .m1_w_data_i(m1_w_data), .m1_w_strb_i(m1_w_strb), .m1_w_ready_o(m1_w_ready),
        .m1_b_valid_o(m1_b_valid), .m1_b_resp_o(m1_b_resp), .m1_b_ready_i(m1_b_ready),
        .s_ar_valid_o(s_ar_valid), .s_ar_addr_o(s_ar_addr), .s_ar_ready_i(s_ar_ready),
        .s_r_valid_i(s_r_valid), .s_r_data_i(s_r_data), .s_r_resp_i(s_r_resp), .s_r_ready_o(s_r_ready),
        .s_aw_valid_o(s_aw_valid), .s_aw_addr_o(s_aw_addr), .s_aw_ready_i(s_aw_ready),
        .s_w_valid_o(s_w_valid), .s_w_data_o(s_w_data), .s_w_strb_o(s_w_strb), .s_w_ready_i(s_w_ready),
        .s_b_valid_i(s_b_valid), .s_b_resp_i(s_b_resp), .s_b_ready_o(s_b_ready)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: read phase 0=idle 1=address 2=data, write phase 0=idle 1=aw 2=w 3=b
    int rph, wph;
    bit rown, rlast;
    bit ar_done0, ar_done1, aw_done, hold_resp;
    int n_reads[2];

    task automatic model_reset();
        rph = 0; wph = 0; rown = 1'b0; rlast = 1'b1;
        ar_done0 = 1'b0; ar_done1 = 1'b0; aw_done = 1'b0;
    endtask

    task automatic model_step();
        bit own_v, own_rr;
        own_v  = rown ? m1_ar_valid : m0_ar_valid;
        own_rr = rown ? m1_r_ready  : m0_r_ready;
        ar_done0 = 1'b0; ar_done1 = 1'b0; aw_done = 1'b0;
        if (rph == 0) begin
            if (m0_ar_valid || m1_ar_valid) begin
                rown = (m0_ar_valid && m1_ar_valid) ? !rlast : m1_ar_valid;
                rph  = 1;
            end
        end else if (rph == 1) begin
            if (!own_v) rph = 0;
            else if (s_ar_ready) begin
                if (rown) ar_done1 = 1'b1; else ar_done0 = 1'b1;
                rph = 2;
            end
        end else if (s_r_valid && own_rr) begin
            rlast = rown;
            n_reads[rown]++;
            rph = 0;
        end
        if (wph == 0 && m1_aw_valid) wph = 1;
        else if (wph == 1 && m1_aw_valid && s_aw_ready) begin wph = 2; aw_done = 1'b1; end
        else if (wph == 2 && m1_w_valid && s_w_ready) wph = 3;
        else if (wph == 3 && s_b_valid && m1_b_ready) wph = 0;
    endtask

    task automatic check_outputs();
        bit a, d, own_v, own_rr;
        logic [AW-1:0] e_ar, e_aw;
        logic [DW+1:0] e_r0, e_r1;
        logic [DW+SW-1:0] e_w;
        a = (rph == 1); d = (rph == 2);
        own_v  = rown ? m1_ar_valid : m0_ar_valid;
        own_rr = rown ? m1_r_ready  : m0_r_ready;
        e_ar = a ? (rown ? m1_ar_addr : m0_ar_addr) : '0;
        e_r0 = (d && !rown) ? {s_r_data, s_r_resp} : '0;
        e_r1 = (d && rown)  ? {s_r_data, s_r_resp} : '0;
        e_aw = (wph == 1) ? m1_aw_addr : '0;
        e_w  = (wph == 2) ? {m1_w_data, m1_w_strb} : '0;
        chk("rd_ctl", 128'({s_ar_valid, m0_ar_ready, m1_ar_ready, m0_r_valid, m1_r_valid, s_r_ready}),
            128'({a & own_v, a & !rown & s_ar_ready, a & rown & s_ar_ready,
                  d & !rown & s_r_valid, d & rown & s_r_valid, d & own_rr}));
        chk("s_ar_addr", 128'(s_ar_addr), 128'(e_ar));
        chk("m0_r_data_resp", 128'({m0_r_data, m0_r_resp}), 128'(e_r0));
        chk("m1_r_data_resp", 128'({m1_r_data, m1_r_resp}), 128'(e_r1));
        chk("wr_ctl", 128'({s_aw_valid, m1_aw_ready, s_w_valid, m1_w_ready, m1_b_valid, s_b_ready}),
            128'({(wph == 1) & m1_aw_valid, (wph == 1) & s_aw_ready, (wph == 2) & m1_w_valid,
                  (wph == 2) & s_w_ready, (wph == 3) & s_b_valid, (wph == 3) & m1_b_ready}));
        chk("s_aw_addr", 128'(s_aw_addr), 128'(e_aw));
        chk("s_w_data_strb", 128'({s_w_data, s_w_strb}), 128'(e_w));
        chk("m1_b_resp", 128'(m1_b_resp), 128'((wph == 3) ? s_b_resp : 2'b00));
    endtask

    task automatic gen_stimulus(input bit force_tie);
        if (ar_done0) m0_ar_valid = 1'b0;
        if (ar_done1) m1_ar_valid = 1'b0;
        if (aw_done)  m1_aw_valid = 1'b0;
        if (force_tie) begin
            m0_ar_valid = 1'b1; m0_ar_addr = 64'h0000_0000_8000_0000;
            m1_ar_valid = 1'b1; m1_ar_addr = 64'h0000_0000_8000_0100;
        end else begin
            if (!m0_ar_valid && $urandom_range(2) == 0) begin
                m0_ar_valid = 1'b1; m0_ar_addr = {$urandom, $urandom};
            end
            if (!m1_ar_valid && $urandom_range(1) == 0) begin
                m1_ar_valid = 1'b1; m1_ar_addr = {$urandom, $urandom};
            end
        end
        m0_r_ready = ($urandom_range(3) != 0);
        m1_r_ready = ($urandom_range(3) != 0);
        s_ar_ready = ($urandom_range(1) != 0);
        s_r_valid  = !hold_resp && ($urandom_range(1) != 0);
        s_r_data   = {$urandom, $urandom};
        s_r_resp   = 2'($urandom_range(3));
        if (!m1_aw_valid && $urandom_range(2) == 0) begin
            m1_aw_valid = 1'b1; m1_aw_addr = {$urandom, $urandom};
        end
        m1_w_valid = ($urandom_range(1) != 0);
        m1_w_data  = {$urandom, $urandom};
        m1_w_strb  = 8'($urandom);
        s_aw_ready = ($urandom_range(1) != 0);
        s_w_ready  = ($urandom_range(1) != 0);
        s_b_valid  = !hold_resp && ($urandom_range(2) == 0);
        s_b_resp   = 2'($urandom_range(3));
        m1_b_ready = ($urandom_range(3) != 0);
    endtask

    task automatic cycle(input bit force_tie);
        gen_stimulus(force_tie);
        #1 check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        m0_ar_valid = 0; m0_ar_addr = '0; m0_r_ready = 0;
        m1_ar_valid = 0; m1_ar_addr = '0; m1_r_ready = 0;
        m1_aw_valid = 0; m1_aw_addr = '0; m1_w_valid = 0; m1_w_data = '0; m1_w_strb = '0; m1_b_ready = 0;
        s_ar_ready = 0; s_r_valid = 0; s_r_data = '0; s_r_resp = 0;
        s_aw_ready = 0; s_w_ready = 0; s_b_valid = 0; s_b_resp = 0;
    endtask

    initial begin
        bit parked;
        n_reads[0] = 0; n_reads[1] = 0;
        hold_resp = 1'b0;
        rst = 1'b1;
        clear_inputs();
        model_reset();
        // live inputs during reset must not leak through
        m0_ar_valid = 1; m1_ar_valid = 1; s_r_valid = 1; s_r_data = 64'h0000_0013_0000_0093;
        m1_aw_valid = 1; m1_w_valid = 1; s_b_valid = 1; s_ar_ready = 1; s_aw_ready = 1; s_w_ready = 1;
        #1 check_outputs();
        repeat (2) @(posedge clk);
        #1 clear_inputs();
        rst = 1'b0;

        cycle(1'b1);
        chk("first_tie_m0_addr", 128'(s_ar_addr), 128'(64'h0000_0000_8000_0000));
        for (int i = 0; i < 1500; i++) cycle(1'b0);

        // park read in data phase and write in response phase, then reset mid-cycle
        hold_resp = 1'b1;
        parked = 1'b0;
        for (int i = 0; i < 500 && !parked; i++) begin
            cycle(1'b0);
            parked = (rph == 2 && wph == 3);
        end
        chk("parked_rdata_wresp", 128'(parked), 128'(1));
        s_r_valid = 1'b1; s_b_valid = 1'b1;
        #2 rst = 1'b1;
        model_reset();
        #1 chk("async_rst_ctl", 128'({s_ar_valid, m0_ar_ready, m1_ar_ready, m0_r_valid, m1_r_valid, s_r_ready,
                                       s_aw_valid, m1_aw_ready, s_w_valid, m1_w_ready, m1_b_valid, s_b_ready}), 128'(0));
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        hold_resp = 1'b0;
        clear_inputs();

        cycle(1'b1);
        chk("post_rst_tie_m0_addr", 128'(s_ar_addr), 128'(64'h0000_0000_8000_0000));
        for (int i = 0; i < 1500; i++) cycle(1'b0);
        chk("no_starve", 128'({n_reads[0] > 20, n_reads[1] > 20}), 128'(2'b11));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
